// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage of the MIPS datapath. Holds the PC, drives the
//               combinational-read instruction memory and captures the
//               returned word into the IF/ID pipeline register. Handles
//               stall, flush and branch/jump redirect, plus a run/halt FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Halt,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] Target,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Misaligned,
  output logic        OutOfRange,
  output logic [31:0] FetchCount
);

  // First byte address past the end of the instruction memory
  localparam logic [31:0] c_PC_LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic        r_misaligned;
  logic        r_out_of_range;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_ifid_instr_nxt;
  logic [31:0] w_ifid_pc4_nxt;
  logic        w_ifid_valid_nxt;
  logic        w_misaligned_nxt;
  logic        w_out_of_range_nxt;
  logic [31:0] w_fetch_count_nxt;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign Address    = r_pc;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: Halt outranks Start in RUN; HALTED exits only by reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_state_nxt = S_RUN;
      S_RUN:    if (Halt)  w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: Redirect > Stall > Flush > normal fetch while
  // running; outside RUN the PC is frozen and IF/ID receives bubbles
  always_comb begin
    w_pc_nxt           = r_pc;
    w_ifid_instr_nxt   = r_ifid_instr;
    w_ifid_pc4_nxt     = r_ifid_pc4;
    w_ifid_valid_nxt   = r_ifid_valid;
    w_misaligned_nxt   = r_misaligned;
    w_out_of_range_nxt = r_out_of_range;
    w_fetch_count_nxt  = r_fetch_count;

    if (r_state == S_RUN) begin
      if (Redirect) begin
        w_pc_nxt         = {Target[31:2], 2'b00};
        w_ifid_instr_nxt = NOP_WORD;
        w_ifid_valid_nxt = 1'b0;
        if (Target[1:0] != 2'b00) w_misaligned_nxt = 1'b1;
      end else if (Stall) begin
        if (Flush) begin
          w_ifid_instr_nxt = NOP_WORD;
          w_ifid_valid_nxt = 1'b0;
        end
      end else if (Flush) begin
        w_pc_nxt         = w_pc_plus4;
        w_ifid_instr_nxt = NOP_WORD;
        w_ifid_valid_nxt = 1'b0;
      end else begin
        w_pc_nxt          = w_pc_plus4;
        w_ifid_instr_nxt  = Instruction;
        w_ifid_pc4_nxt    = w_pc_plus4;
        w_ifid_valid_nxt  = 1'b1;
        w_fetch_count_nxt = r_fetch_count + 32'd1;
      end
      // The fetch itself still proceeds; the memory aliases the address
      if (r_pc >= c_PC_LIMIT) w_out_of_range_nxt = 1'b1;
    end else begin
      w_ifid_instr_nxt = NOP_WORD;
      w_ifid_valid_nxt = 1'b0;
    end
  end

  // PC, IF/ID register, sticky flags and fetch counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc           <= RESET_PC;
      r_ifid_instr   <= NOP_WORD;
      r_ifid_pc4     <= 32'd0;
      r_ifid_valid   <= 1'b0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
      r_fetch_count  <= 32'd0;
    end else begin
      r_pc           <= w_pc_nxt;
      r_ifid_instr   <= w_ifid_instr_nxt;
      r_ifid_pc4     <= w_ifid_pc4_nxt;
      r_ifid_valid   <= w_ifid_valid_nxt;
      r_misaligned   <= w_misaligned_nxt;
      r_out_of_range <= w_out_of_range_nxt;
      r_fetch_count  <= w_fetch_count_nxt;
    end
  end

  assign IFID_Instruction = r_ifid_instr;
  assign IFID_PCPlus4     = r_ifid_pc4;
  assign IFID_Valid       = r_ifid_valid;
  assign Misaligned       = r_misaligned;
  assign OutOfRange       = r_out_of_range;
  assign FetchCount       = r_fetch_count;

endmodule

`default_nettype wire
